fazyrv_rf_mem: RTL

FAZYRV_RF_MEM -- requirements
Module: fazyrv_rf_mem

---
 rtl/fazyrv_pkg.sv | 19 +
 rtl/fazyrv_rf_mem_array.sv | 35 +++
 rtl/fazyrv_rf_mem.sv | 129 ++++++++++++
 3 files changed

// File: rtl/fazyrv_pkg.sv
// Shared types and constants for the FazyRV register file storage.
// Each stored word is 32 data bits with an even-parity bit on top.
package fazyrv_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_mem_state_e;

    localparam int RF_DATA_W  = 32;
    localparam int RF_PAR_W   = 1;
    localparam int RF_WORD_W  = RF_DATA_W + RF_PAR_W;
    localparam int RF_PAR_BIT = RF_DATA_W;

    function automatic logic rf_par(input logic [RF_DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/fazyrv_rf_mem_array.sv
// Raw parity-extended storage: one write port, one or two read ports, no reset.
// Reads are combinational so the caller can check parity before registering.
module fazyrv_rf_mem_array
    import fazyrv_pkg::*;
#(
    parameter int ADRWIDTH  = 5,
    parameter int DUAL_PORT = 1
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [ADRWIDTH-1:0]  waddr_i,
    input  logic [RF_WORD_W-1:0] wdata_i,
    input  logic [ADRWIDTH-1:0]  raddr_a_i,
    input  logic [ADRWIDTH-1:0]  raddr_b_i,
    output logic [RF_WORD_W-1:0] rdata_a_o,
    output logic [RF_WORD_W-1:0] rdata_b_o
);

    logic [RF_WORD_W-1:0] mem_q [2**ADRWIDTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_a_o = mem_q[raddr_a_i];

    if (DUAL_PORT != 0) begin : g_port_b
        assign rdata_b_o = mem_q[raddr_b_i];
    end else begin : g_no_port_b
        logic unused_b;
        assign unused_b  = ^raddr_b_i;
        assign rdata_b_o = '0;
    end

endmodule

// File: rtl/fazyrv_rf_mem.sv
// Register file memory wrapper: post-reset clear sequence, write-first
// forwarding, x0 masking and sticky parity error detection.
module fazyrv_rf_mem
    import fazyrv_pkg::*;
#(
    parameter int ADRWIDTH     = 5,
    parameter int DUAL_PORT    = 1,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                we_i,
    input  logic [ADRWIDTH-1:0] waddr_i,
    input  logic [31:0]         wdata_i,
    input  logic                inj_par_i,
    input  logic [ADRWIDTH-1:0] raddr_ab_i,
    input  logic [ADRWIDTH-1:0] raddr_b_i,
    output logic [31:0]         rdata_ab_o,
    output logic [31:0]         rdata_b_o,
    output logic                busy_o,
    output logic                par_err_o,
    input  logic                err_clr_i
);

    localparam logic [ADRWIDTH-1:0] LAST_ADR = ADRWIDTH'((2**ADRWIDTH) - 1);

    rf_mem_state_e        state_q, state_d;
    logic [ADRWIDTH-1:0]  cnt_q, cnt_d;
    logic [31:0]          rdata_ab_q, rdata_ab_d;
    logic [31:0]          rdata_b_q, rdata_b_d;
    logic                 par_err_q, par_err_d;
    logic                 clearing, wr_ok, err_a, err_b;
    logic [ADRWIDTH-1:0]  arr_waddr, arr_raddr_a;
    logic [RF_WORD_W-1:0] arr_wdata, arr_rdata_a, arr_rdata_b;

    assign clearing = (state_q == RF_CLEAR);
    assign wr_ok    = we_i && !clearing && (waddr_i != '0);

    always_comb begin
        arr_waddr   = waddr_i;
        arr_wdata   = {rf_par(wdata_i) ^ inj_par_i, wdata_i};
        arr_raddr_a = raddr_ab_i;
        if (clearing) begin
            arr_waddr = cnt_q;
            arr_wdata = {rf_par(32'h0), 32'h0};
        end
        // A single physical port is taken by the write address when writing.
        if (DUAL_PORT == 0 && we_i) arr_raddr_a = waddr_i;
    end

    fazyrv_rf_mem_array #(
        .ADRWIDTH  (ADRWIDTH),
        .DUAL_PORT (DUAL_PORT)
    ) u_array (
        .clk_i     (clk_i),
        .we_i      (clearing || wr_ok),
        .waddr_i   (arr_waddr),
        .wdata_i   (arr_wdata),
        .raddr_a_i (arr_raddr_a),
        .raddr_b_i (raddr_b_i),
        .rdata_a_o (arr_rdata_a),
        .rdata_b_o (arr_rdata_b)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == RF_CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ADR) state_d = RF_READY;
        end
    end

    always_comb begin
        rdata_ab_d = rdata_ab_q;
        rdata_b_d  = rdata_b_q;
        err_a      = 1'b0;
        err_b      = 1'b0;
        if (clearing) begin
            rdata_ab_d = '0;
            rdata_b_d  = '0;
        end else if (DUAL_PORT == 0 && we_i) begin
            if (waddr_i == raddr_ab_i) rdata_ab_d = (waddr_i != '0) ? wdata_i : '0;
        end else begin
            if (raddr_ab_i == '0) begin
                rdata_ab_d = '0;
            end else if (we_i && waddr_i == raddr_ab_i) begin
                rdata_ab_d = wdata_i;
            end else begin
                rdata_ab_d = arr_rdata_a[RF_DATA_W-1:0];
                err_a      = rf_par(arr_rdata_a[RF_DATA_W-1:0]) != arr_rdata_a[RF_PAR_BIT];
            end
            if (DUAL_PORT != 0) begin
                if (raddr_b_i == '0) begin
                    rdata_b_d = '0;
                end else if (we_i && waddr_i == raddr_b_i) begin
                    rdata_b_d = wdata_i;
                end else begin
                    rdata_b_d = arr_rdata_b[RF_DATA_W-1:0];
                    err_b     = rf_par(arr_rdata_b[RF_DATA_W-1:0]) != arr_rdata_b[RF_PAR_BIT];
                end
            end
        end
        // A new error outranks a simultaneous clear.
        par_err_d = err_a || err_b || (par_err_q && !err_clr_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= (CLEAR_ON_RST != 0) ? RF_CLEAR : RF_READY;
            cnt_q      <= '0;
            rdata_ab_q <= '0;
            rdata_b_q  <= '0;
            par_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rdata_ab_q <= rdata_ab_d;
            rdata_b_q  <= rdata_b_d;
            par_err_q  <= par_err_d;
        end
    end

    assign rdata_ab_o = rdata_ab_q;
    assign rdata_b_o  = (DUAL_PORT != 0) ? rdata_b_q : '0;
    assign busy_o     = clearing;
    assign par_err_o  = par_err_q;

endmodule
